// File: rtl/uart_rx_packer_fifo.sv
// rtl/uart_rx_packer_fifo.sv - 8N1 UART receiver with byte packer, idle flush and word FIFO
module uart_rx_packer_fifo #(
  parameter int BAUD_DIV   = 216,
  parameter int BYTES      = 8,
  parameter int DEPTH_LOG2 = 9,
  parameter int MSB_FIRST  = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       uart_rx,
  input  logic                       rd_en,
  output logic [8*BYTES-1:0]         dout,
  output logic [$clog2(BYTES+1)-1:0] dout_bytes,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH_LOG2:0]        level,
  output logic                       frame_err,
  output logic [7:0]                 overflow_cnt
);

  localparam int W     = 8 * BYTES;
  localparam int CW    = $clog2(BYTES + 1);
  localparam int BW    = $clog2(BAUD_DIV);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int LIMIT = TIMEOUT * BAUD_DIV;
  localparam int TW    = $clog2(LIMIT + 2);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] WORD_CNT  = CW'(BYTES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LIMIT - 1);
  localparam logic [PW-1:0] DEPTH_W   = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic            rx_s1, rx_s2, rx_d;
  logic            armed;
  logic [BW-1:0]   arm_cnt;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            baud_clr, data_sample, byte_valid;

  logic [W-1:0]    word, word_nxt;
  logic [CW-1:0]   count;
  logic [TW-1:0]   tmo_cnt;
  logic            flush;
  logic            commit_valid;
  logic [W-1:0]    commit_word;
  logic [CW-1:0]   commit_bytes;

  logic [CW+W-1:0] mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Arm only after a full bit-time of continuous idle line; a bad stop bit disarms
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else if (frame_err) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else if (!armed) begin
      if (!rx_s2)                    arm_cnt <= '0;
      else if (arm_cnt == BAUD_LAST) armed   <= 1'b1;
      else                           arm_cnt <= arm_cnt + 1'b1;
    end
  end

  // Receiver state register, bit timing and LSB-first data shift
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_clr ? '0 : baud_cnt + 1'b1;
      if (state == IDLE && state_nxt == START) bit_cnt <= '0;
      if (data_sample) begin
        shift   <= {rx_s2, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Receiver next state and single-cycle sample strobes
  always_comb begin
    state_nxt   = state;
    baud_clr    = 1'b0;
    data_sample = 1'b0;
    byte_valid  = 1'b0;
    frame_err   = 1'b0;
    case (state)
      IDLE: if (armed && rx_d && !rx_s2) begin
        state_nxt = START;
        baud_clr  = 1'b1;
      end
      START: if (baud_cnt == HALF_LAST) begin
        baud_clr  = 1'b1;
        state_nxt = rx_s2 ? IDLE : DATA;
      end
      DATA: if (baud_cnt == BAUD_LAST) begin
        baud_clr    = 1'b1;
        data_sample = 1'b1;
        if (bit_cnt == 3'd7) state_nxt = STOP;
      end
      STOP: if (baud_cnt == BAUD_LAST) begin
        baud_clr  = 1'b1;
        state_nxt = IDLE;
        if (rx_s2) byte_valid = 1'b1;
        else       frame_err  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Place the received byte into its slot for the configured byte order
  always_comb begin
    word_nxt = word;
    for (int k = 0; k < BYTES; k++) begin
      if (count == CW'(k)) begin
        if (MSB_FIRST != 0) word_nxt[W-8-8*k +: 8] = shift;
        else                word_nxt[8*k +: 8]     = shift;
      end
    end
  end

  assign flush = (TIMEOUT != 0) && (count != '0) && (state == IDLE) && (tmo_cnt == TMO_LAST);

  // Packer: accumulate bytes, commit full words or flush partial ones on idle timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word         <= '0;
      count        <= '0;
      tmo_cnt      <= '0;
      commit_valid <= 1'b0;
      commit_word  <= '0;
      commit_bytes <= '0;
    end else begin
      commit_valid <= 1'b0;
      if (byte_valid) begin
        word    <= word_nxt;
        count   <= count + 1'b1;
        tmo_cnt <= '0;
      end else if (count == WORD_CNT || flush) begin
        commit_valid <= 1'b1;
        commit_word  <= word;
        commit_bytes <= count;
        word         <= '0;
        count        <= '0;
        tmo_cnt      <= '0;
      end else if (count != '0 && state == IDLE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  assign level = wptr - rptr;
  assign full  = (level == DEPTH_W);
  assign empty = (level == '0);

  // FIFO storage; contents need no reset since pointers gate every read
  always_ff @(posedge clk) begin
    if (commit_valid && !full) mem[wptr[DEPTH_LOG2-1:0]] <= {commit_bytes, commit_word};
  end

  // FIFO pointers, registered read port and saturating drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      dout         <= '0;
      dout_bytes   <= '0;
      overflow_cnt <= '0;
    end else begin
      if (commit_valid) begin
        if (!full)                     wptr         <= wptr + 1'b1;
        else if (overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 1'b1;
      end
      if (rd_en && !empty) begin
        {dout_bytes, dout} <= mem[rptr[DEPTH_LOG2-1:0]];
        rptr               <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packer_fifo.sv
// tb/tb_uart_rx_packer_fifo.sv - scoreboard bench for uart_rx_packer_fifo
module tb_uart_rx_packer_fifo;
  localparam int BAUD  = 16;
  localparam int NB    = 4;
  localparam int DL    = 2;
  localparam int DEPTH = 4;
  localparam int TMO   = 6;
  localparam int GAP   = 2;
  localparam int FLEN  = (10 + GAP) * BAUD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        rd_en = 1'b0;
  logic [31:0] dout;
  logic [2:0]  dout_bytes;
  logic        full, empty;
  logic [2:0]  level;
  logic        frame_err;
  logic [7:0]  overflow_cnt;

  uart_rx_packer_fifo #(
    .BAUD_DIV(BAUD), .BYTES(NB), .DEPTH_LOG2(DL), .MSB_FIRST(1), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .rd_en(rd_en),
    .dout(dout), .dout_bytes(dout_bytes), .full(full), .empty(empty),
    .level(level), .frame_err(frame_err), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] w; logic [2:0] n; } exp_t;
  typedef struct { logic [7:0] b0, b1, b2, b3; logic [31:0] w; } vec_t;

  exp_t        sb[$];
  vec_t        vecs [4];
  int          checks = 0;
  int          errors = 0;
  int          exp_ovf = 0;
  int          fe_cnt = 0;
  int          last_c0 = 0;
  int          c_ref = 0;
  logic        empty_hist [FLEN];
  logic [31:0] last_word = '0;
  logic [7:0]  ob;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (frame_err) fe_cnt++;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame  = {stop_bit, b, 1'b0};
    fe_cnt = 0;
    for (int k = 0; k < FLEN; k++) begin
      @(negedge clk);
      if (k == 0) last_c0 = cyc;
      empty_hist[k] = empty;
      if (frame_err) fe_cnt++;
      if (k % BAUD == 0) uart_rx = (k / BAUD < 10) ? frame[k / BAUD] : 1'b1;
    end
  endtask

  task automatic push_exp(input logic [31:0] w, input logic [2:0] n);
    exp_t e;
    e.w = w;
    e.n = n;
    if (sb.size() == DEPTH) begin
      if (exp_ovf < 255) exp_ovf++;
    end else begin
      sb.push_back(e);
    end
  endtask

  task automatic read_check(input string name);
    exp_t e;
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: actual read with nothing expected, required expected word", name);
    end else begin
      e = sb.pop_front();
      check({name, " word"}, dout, e.w);
      check({name, " bytes"}, {29'd0, dout_bytes}, {29'd0, e.n});
      last_word = e.w;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hAABBCCDD};
    vecs[1] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h01020304};
    vecs[2] = '{8'hFF, 8'h00, 8'h80, 8'h7F, 32'hFF00807F};
    vecs[3] = '{8'h3C, 8'hC3, 8'h5A, 8'hA5, 32'h3CC35AA5};

    tick(3);
    check("rst dout", dout, 32'h0);
    check("rst dout_bytes", {29'd0, dout_bytes}, 32'h0);
    check("rst empty", {31'd0, empty}, 32'h1);
    check("rst full", {31'd0, full}, 32'h0);
    check("rst level", {29'd0, level}, 32'h0);
    check("rst frame_err", {31'd0, frame_err}, 32'h0);
    check("rst overflow", {24'd0, overflow_cnt}, 32'h0);
    rst_n = 1'b1;
    tick(2 * BAUD);

    // full words, MSB-first packing
    for (int v = 0; v < 4; v++) begin
      send_byte(vecs[v].b0, 1'b1);
      send_byte(vecs[v].b1, 1'b1);
      send_byte(vecs[v].b2, 1'b1);
      send_byte(vecs[v].b3, 1'b1);
      push_exp(vecs[v].w, 3'd4);
      if (v == 0) begin
        check("latency empty before", {31'd0, empty_hist[155]}, 32'h1);
        check("latency empty after", {31'd0, empty_hist[158]}, 32'h0);
      end
      check("vec level", {29'd0, level}, sb.size());
      read_check("vec");
    end

    // idle timeout flushes a partial word
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    push_exp(32'h11223300, 3'd3);
    wait_until(last_c0 + 250);
    check("tmo early empty", {31'd0, empty}, 32'h1);
    wait_until(last_c0 + 253);
    check("tmo flush empty", {31'd0, empty}, 32'h0);
    read_check("tmo");

    // a new byte restarts the idle timer
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    check("restart no flush", {31'd0, empty_hist[61]}, 32'h1);
    push_exp(32'h44556600, 3'd3);
    wait_until(last_c0 + 250);
    check("restart early empty", {31'd0, empty}, 32'h1);
    wait_until(last_c0 + 253);
    check("restart flush empty", {31'd0, empty}, 32'h0);
    read_check("restart");

    // short glitch is rejected silently
    fe_cnt = 0;
    @(negedge clk);
    uart_rx = 1'b0;
    tick(5);
    uart_rx = 1'b1;
    tick(3 * BAUD);
    check("glitch frame_err", fe_cnt, 0);
    check("glitch empty", {31'd0, empty}, 32'h1);

    // bad stop bit drops the byte and pulses frame_err once
    send_byte(8'h01, 1'b1);
    check("good byte frame_err", fe_cnt, 0);
    send_byte(8'h02, 1'b0);
    check("bad stop frame_err", fe_cnt, 1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h05, 1'b1);
    push_exp(32'h01030405, 3'd4);
    read_check("frame");

    // overflow: five words, no reads
    for (int j = 1; j <= 5; j++) begin
      logic [31:0] w;
      for (int k = 0; k < NB; k++) begin
        ob = 8'(16 * j + k);
        send_byte(ob, 1'b1);
        w[31 - 8 * k -: 8] = ob;
      end
      push_exp(w, 3'd4);
      if (j == 4) begin
        check("ovf full", {31'd0, full}, 32'h1);
        check("ovf level", {29'd0, level}, 32'd4);
      end
    end
    check("ovf count", {24'd0, overflow_cnt}, exp_ovf);
    for (int j = 0; j < DEPTH; j++) read_check("ovf read");
    check("ovf drained empty", {31'd0, empty}, 32'h1);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("empty read dout", dout, last_word);
    check("empty read level", {29'd0, level}, 32'h0);

    // reset with the line held low must not produce a byte or an error
    @(negedge clk);
    uart_rx = 1'b0;
    tick(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    exp_ovf = 0;
    check("rst2 overflow", {24'd0, overflow_cnt}, exp_ovf);
    fe_cnt = 0;
    tick(3 * BAUD);
    uart_rx = 1'b1;
    tick(12 * BAUD);
    check("rst2 frame_err", fe_cnt, 0);
    check("rst2 empty", {31'd0, empty}, 32'h1);
    send_byte(8'h5A, 1'b1);
    push_exp(32'h5A000000, 3'd1);
    c_ref = last_c0;
    wait_until(c_ref + 253);
    check("rst2 level", {29'd0, level}, sb.size());
    read_check("rst2 5A");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
